// File: rtl/mdu_ctrl_if.sv
// E-stage MDU handshake bundle: operation/operands/flush in, accept/busy/stall and HI/LO out.
// The pipeline side uses the master modport, the sequencer uses the slave modport.
interface mdu_ctrl_if;
    logic [3:0]  E_MDUOp;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        D_IsMDU;
    logic        Req;
    logic        start;
    logic        busy;
    logic        MDU_Stall;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output E_MDUOp,
        output E_A,
        output E_B,
        output D_IsMDU,
        output Req,
        input  start,
        input  busy,
        input  MDU_Stall,
        input  HI,
        input  LO
    );

    modport slave (
        input  E_MDUOp,
        input  E_A,
        input  E_B,
        input  D_IsMDU,
        input  Req,
        output start,
        output busy,
        output MDU_Stall,
        output HI,
        output LO
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, models fixed op latency and stalls MDU users in D.
// Define MDU_MADD_EN to accept madd/maddu (ops 7/8); otherwise those codes are treated as none.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic       clk,
    input logic       reset,
    mdu_ctrl_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    typedef enum logic [3:0] {
        OpNone  = 4'd0,
        OpMult  = 4'd1,
        OpMultu = 4'd2,
        OpDiv   = 4'd3,
        OpDivu  = 4'd4,
        OpMthi  = 4'd5,
        OpMtlo  = 4'd6,
        OpMadd  = 4'd7,
        OpMaddu = 4'd8
    } mdu_op_e;

    localparam logic [3:0] MultCnt = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DivCnt  = 4'(DIV_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [63:0] pend_q, pend_d;

    logic        start;
    logic        op_valid;
    logic        op_long;
    logic        op_mthi;
    logic        op_mtlo;
    logic [3:0]  long_cnt;
    logic [63:0] long_res;

    // Products: the low 64 bits of a 64x64 product of extended operands are exact.
    logic [63:0] a_sx, b_sx, a_zx, b_zx;
    logic [63:0] prod_s, prod_u;

    assign a_sx   = {{32{bus.E_A[31]}}, bus.E_A};
    assign b_sx   = {{32{bus.E_B[31]}}, bus.E_B};
    assign a_zx   = {32'd0, bus.E_A};
    assign b_zx   = {32'd0, bus.E_B};
    assign prod_s = a_sx * b_sx;
    assign prod_u = a_zx * b_zx;

    // Signed divide via magnitudes; 0x80000000 / -1 falls out as quotient 0x80000000, rem 0.
    logic        a_neg, b_neg, div_by_zero;
    logic [31:0] a_abs, b_abs;
    logic [31:0] q_mag, r_mag;
    logic [31:0] q_s, r_s, q_u, r_u;
    logic [63:0] div_s_res, div_u_res;

    assign a_neg       = bus.E_A[31];
    assign b_neg       = bus.E_B[31];
    assign a_abs       = a_neg ? (~bus.E_A + 32'd1) : bus.E_A;
    assign b_abs       = b_neg ? (~bus.E_B + 32'd1) : bus.E_B;
    assign div_by_zero = (bus.E_B == 32'd0);

    always_comb begin
        q_mag = '0;
        r_mag = '0;
        q_u   = '0;
        r_u   = '0;
        if (!div_by_zero) begin
            q_mag = a_abs / b_abs;
            r_mag = a_abs % b_abs;
            q_u   = bus.E_A / bus.E_B;
            r_u   = bus.E_A % bus.E_B;
        end
    end

    assign q_s = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign r_s = a_neg ? (~r_mag + 32'd1) : r_mag;

    assign div_s_res = div_by_zero ? {bus.E_A, 32'hFFFF_FFFF} : {r_s, q_s};
    assign div_u_res = div_by_zero ? {bus.E_A, 32'hFFFF_FFFF} : {r_u, q_u};

    // Decode the E-stage op into acceptance class, latency and result.
    always_comb begin
        op_valid = 1'b0;
        op_long  = 1'b0;
        op_mthi  = 1'b0;
        op_mtlo  = 1'b0;
        long_cnt = '0;
        long_res = '0;
        case (bus.E_MDUOp)
            OpMult: begin
                op_valid = 1'b1;
                op_long  = 1'b1;
                long_cnt = MultCnt;
                long_res = prod_s;
            end
            OpMultu: begin
                op_valid = 1'b1;
                op_long  = 1'b1;
                long_cnt = MultCnt;
                long_res = prod_u;
            end
            OpDiv: begin
                op_valid = 1'b1;
                op_long  = 1'b1;
                long_cnt = DivCnt;
                long_res = div_s_res;
            end
            OpDivu: begin
                op_valid = 1'b1;
                op_long  = 1'b1;
                long_cnt = DivCnt;
                long_res = div_u_res;
            end
            OpMthi: begin
                op_valid = 1'b1;
                op_mthi  = 1'b1;
            end
            OpMtlo: begin
                op_valid = 1'b1;
                op_mtlo  = 1'b1;
            end
`ifdef MDU_MADD_EN
            // Accumulate onto HI/LO as seen at acceptance; wraps at 64 bits.
            OpMadd: begin
                op_valid = 1'b1;
                op_long  = 1'b1;
                long_cnt = MultCnt;
                long_res = {hi_q, lo_q} + prod_s;
            end
            OpMaddu: begin
                op_valid = 1'b1;
                op_long  = 1'b1;
                long_cnt = MultCnt;
                long_res = {hi_q, lo_q} + prod_u;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        pend_d  = pend_q;
        start   = 1'b0;
        case (state_q)
            StIdle: begin
                // A flush request drops the E-stage op so younger ops never touch HI/LO.
                if (!bus.Req && op_valid) begin
                    start = 1'b1;
                    if (op_mthi) begin
                        hi_d = bus.E_A;
                    end else if (op_mtlo) begin
                        lo_d = bus.E_A;
                    end else if (op_long) begin
                        pend_d  = long_res;
                        cnt_d   = long_cnt;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (cnt_q == 4'd0) begin
                    hi_d    = pend_q[63:32];
                    lo_d    = pend_q[31:0];
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy_d = (state_d == StRun);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.start     = start;
    assign bus.busy      = busy_q;
    assign bus.MDU_Stall = (start | busy_q) & bus.D_IsMDU;
    assign bus.HI        = hi_q;
    assign bus.LO        = lo_q;

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Sequencer for the shared multiply/divide resource in the E stage of the pipelined MIPS core. Accepts MDU instructions from E, keeps the HI/LO registers, emulates fixed multi-cycle latency with a busy counter, and raises the stall request that holds later MDU instructions in D. It ignores new E-stage operations during an exception or interrupt flush, so HI/LO commit only for instructions older than the faulting one.

## Interface
- MULT_CYCLES, default 5: busy cycles for mult/multu (and madd/maddu when enabled).
- DIV_CYCLES, default 10: busy cycles for div/divu.
- clk  in  1  system clock; every register updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- E_MDUOp  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu; 9–15 are treated as none.
- E_A, E_B  in  32 each  forwarded rs and rt operands.
- D_IsMDU  in  1  the D-stage instruction uses the MDU (any op above, or mfhi/mflo).
- Req  in  1  exception or interrupt flush request from CP0.
- start  out  1  combinational; high in the cycle an op is accepted.
- busy  out  1  registered; high while a mult or div is in flight.
- MDU_Stall  out  1  combinational; `(start | busy) & D_IsMDU`.
- HI, LO  out  32 each  architectural HI and LO registers.

## Operation
- FSM states:
  - IDLE: no op in flight.
  - RUN: op in flight; counter `cnt` is 4 bits; latched op, operands and pending result are held.
- Acceptance: an op is accepted when the state is IDLE, `Req == 0` and `E_MDUOp` is valid (1–8). In that case `start = 1`.
- Ops presented when they cannot be accepted are dropped silently: while busy, while `Req = 1`, or op 7/8 without the macro. No state changes.
- mthi/mtlo: accepted in IDLE only. They write HI (or LO) with E_A at the next edge and never enter RUN.
- mult/multu/madd/maddu/div/divu:
  - On acceptance, compute the 64-bit result and latch it as pending.
  - Load `cnt = N-1` and enter RUN.
- Arithmetic rules:
  - mult is signed 32×32→64; multu is unsigned.
  - div: LO = quotient and HI = remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend. divu is unsigned.
  - Divide by zero: HI = E_A and LO = 32'hFFFFFFFF.
  - `0x80000000 / -1`: LO = 0x80000000, HI = 0.
- RUN: decrement `cnt` each cycle. In the cycle `cnt == 0`, {HI,LO} take the pending result at the clock edge and the state returns to IDLE.
- Req mid-operation: an op already in RUN completes unchanged. Req only blocks acceptance.
- Reset at any time: state = IDLE, busy = 0, cnt = 0, HI = LO = 0, pending = 0.

## Timing
- Op accepted in cycle T (start = 1).
  - busy = 1 in cycles T+1 … T+N.
  - HI/LO hold the new value from cycle T+N+1.
  - busy = 0 in cycle T+N+1.
  - The next op can be accepted in T+N+1.
- mthi/mtlo accepted in T: the register is updated from T+1. busy stays 0.
- MDU_Stall is high in cycle T (if D_IsMDU) and throughout T+1 … T+N. This holds D so mfhi/mflo never read stale values.
- Outputs after reset: start = 0 (given no valid op), busy = 0, MDU_Stall = 0, HI = 0, LO = 0.

## Configuration
- MDU_MADD_EN defined:
  - Ops 7/8 are accepted with MULT_CYCLES latency.
  - Pending = {HI,LO} + signed product (op 7) or + unsigned product (op 8), with 64-bit wrap-around.
  - The {HI,LO} addend is the value sampled at acceptance.
- MDU_MADD_EN undefined: ops 7/8 are treated as none. start stays 0 and there are no side effects.

## Test plan
- Reset low mid-RUN (3 cycles into a div): busy = 0, HI = LO = 0 immediately; after release, a new mult is accepted in the first cycle.
- mult with E_A = 0xFFFFFFFE (−2), E_B = 3:
  - busy for 5 cycles.
  - HI = 0xFFFFFFFF and LO = 0xFFFFFFFA at T+6.
  - multu of the same operands gives HI = 0x00000002, LO = 0xFFFFFFFA.
- div −7/2 gives LO = 0xFFFFFFFD, HI = 0xFFFFFFFF after 10 busy cycles. div 5/0 gives HI = 5, LO = 0xFFFFFFFF.
- mult accepted at T with D_IsMDU held at 1: MDU_Stall = 1 in T…T+5 and 0 at T+6. A mthi presented during busy is ignored, so HI is unchanged.
- Req = 1 in the same cycle as div in E: start = 0, busy stays 0, HI/LO unchanged. Req raised at T+2 of a running mult: the result still commits at T+6.
- With MDU_MADD_EN: HI:LO = 0:0xFFFFFFFF, then maddu with operands 1 and 1 gives HI = 1, LO = 0. Without MDU_MADD_EN, the same op leaves start = 0 and HI/LO unchanged.
